segment_sequencer: RTL and testbench
====================================

# segment_sequencer

Sequences the train-position datapath: it takes the six synchronized track-sensor levels, tracks which segment the train occupies, times each segment transit in clock cycles, and hands each measured transit time to the predictor through a valid/ready handshake. It also drives load/enable for the external position counter. It detects out-of-order sensor hits and stalled trains, and holds a fault until software clears it. It sits between the sensor synchronizer and the counter/predictor/selector datapath.

## Interface
- N_SEG, 6, number of track sensors/segments (ring topology)
- CNT_W, 16, transit timer and measurement width
- TIMEOUT, 16'd50000, cycles without the expected sensor before a stall fault
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sensor  in  N_SEG  synchronized sensor levels; bit i is sensor S(i+1)
- start  in  1  one-cycle arm request
- stop  in  1  one-cycle abort; returns to IDLE from any state
- clear  in  1  one-cycle fault acknowledge
- seg  out  3  current segment index, 0..N_SEG-1
- cnt_ld  out  1  one-cycle load strobe for the position counter
- cnt_en  out  1  position counter enable
- meas_time  out  CNT_W  measured transit cycles
- meas_valid  out  1  meas_time valid; held until accepted
- meas_ready  in  1  predictor accepts meas_time
- overrun  out  1  sticky: a measurement was dropped
- fault  out  1  fault state indicator
- fault_code  out  2  0 none, 1 multi-hit, 2 out-of-order, 3 timeout

## Operation
- States: IDLE, ARMED, TIMING, FAULT.
- Edge detection: `edge = sensor & ~prev`. In IDLE, prev tracks sensor every cycle, so sensors that are already high at arm time produce no edge.
- IDLE:
  - start -> ARMED.
- ARMED:
  - Exactly one edge on bit i -> seg=i, timer=0, cnt_ld pulse, TIMING.
  - More than one edge in the same cycle -> FAULT, code 1.
- TIMING:
  - cnt_en=1. The timer increments every cycle and saturates at all-ones.
  - Accept condition: the edge on the expected sensor (seg+1 mod N_SEG; 5 wraps to 0) is the only edge that cycle.
  - On accept: seg advances, cnt_ld pulses, timer restarts, and a measurement is produced. meas_time equals the distance in cycles between the two accepted edges.
  - An edge on the current segment's own sensor is ignored.
  - Any other edge, including the expected edge combined with another bit -> FAULT, code 2.
  - Timer reaching TIMEOUT with no accept -> FAULT, code 3.
- FAULT:
  - fault=1, cnt_en=0, seg is frozen.
  - clear -> IDLE with fault_code=0.
- stop:
  - Any state -> IDLE next cycle. Clears timer and cnt_en; does not clear overrun.
  - stop takes priority over clear, start and edges in the same cycle.
- Measurement buffer (single entry):
  - When a measurement is produced and the buffer is empty or being accepted that cycle (meas_valid & meas_ready), load it and keep meas_valid=1.
  - When the buffer is full and not accepted, drop the new value, keep the old one, and set overrun.
  - overrun clears only on rst.
  - The buffer keeps draining in IDLE and FAULT.

## Timing
- Reset values:
  - State IDLE, seg=0, cnt_ld=0, cnt_en=0.
  - meas_time=0, meas_valid=0, overrun=0, fault=0, fault_code=0, timer=0, prev=0.
- All outputs are registered.
- An edge on sensor in cycle n is detected in cycle n. The resulting transition, cnt_ld and meas_valid are visible at cycle n+1.
- Edges at cycles n and n+D give meas_time=D. D saturates at 2^CNT_W-1.
- The timeout fault is visible TIMEOUT+1 cycles after the last accept.
- cnt_ld is a one-cycle pulse. It is never asserted in IDLE or FAULT.
- Handshake: the transfer occurs on a cycle with meas_valid & meas_ready. meas_valid drops the next cycle unless a new measurement is loaded that same cycle.
- rst during TIMING with meas_valid high: all outputs return to their reset values next cycle, and the pending measurement is discarded.

## Structure
- Package segment_pkg:
  - state enum (IDLE, ARMED, TIMING, FAULT).
  - fault code constants FLT_NONE, FLT_MULTI, FLT_ORDER, FLT_TIMEOUT.
  - default N_SEG.
  - next-segment wrap function.
- Sub-module sensor_edge_detect: holds the prev register, provides the IDLE tracking enable, and outputs the edge vector and the one-hot check (single/multi).
- FSM, timer and measurement buffer live in segment_sequencer.

## Test plan
- Normal lap: start; hit S1,S2,S3,S4,S5,S6,S1 spaced 100 cycles apart with meas_ready=1 -> seg steps 0..5 then wraps to 0; six measurements of 100; no fault.
- Out-of-order: ARMED, hit S3 then S5 -> FAULT with fault_code=2 at the cycle after the S5 edge, cnt_en=0; clear -> IDLE with fault_code=0.
- Timeout: TIMEOUT=20, hit S2 only -> fault_code=3 exactly 21 cycles after the S2 edge.
- Backpressure: meas_ready=0, two accepts 10 cycles apart -> meas_time stays at the first value and overrun=1; raise meas_ready -> one transfer, then meas_valid=0.
- Simultaneous/priority cases:
  - In ARMED, S1 and S4 together -> fault_code=1.
  - stop asserted together with the expected edge -> IDLE, no measurement produced.
- Reset mid-run: assert rst in TIMING with meas_valid=1 -> all outputs at reset values next cycle. Sensor levels already high produce no edge after re-arming.

Source files
------------

// File: rtl/segment_pkg.sv
`default_nettype none
// ============================================================================
// Module   : segment_pkg
// Brief    : Shared types, fault codes and ring helpers for segment_sequencer
// Revision : 1.0 - initial release
// ============================================================================
package segment_pkg;

    localparam int unsigned N_SEG_DEFAULT = 6;
    localparam int unsigned SEG_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_TIMING = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_MULTI   = 2'd1;
    localparam logic [1:0] FLT_ORDER   = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT = 2'd3;

    // Successor on the sensor ring; the last segment wraps to 0.
    function automatic logic [SEG_W-1:0] next_seg(input logic [SEG_W-1:0] s,
                                                  input int unsigned n_seg);
        if ({29'd0, s} == n_seg - 32'd1)
            return '0;
        return s + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/segment_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : segment_sequencer_if
// Brief    : Sensor/control inputs, counter strobes and measurement handshake
// Revision : 1.0 - initial release
// ============================================================================
interface segment_sequencer_if import segment_pkg::*; #(
    parameter int unsigned N_SEG = N_SEG_DEFAULT,
    parameter int unsigned CNT_W = 16
) ();

    logic [N_SEG-1:0] sensor;
    logic             start;
    logic             stop;
    logic             clear;
    logic [SEG_W-1:0] seg;
    logic             cnt_ld;
    logic             cnt_en;
    logic [CNT_W-1:0] meas_time;
    logic             meas_valid;
    logic             meas_ready;
    logic             overrun;
    logic             fault;
    logic [1:0]       fault_code;

    modport master (
        input  sensor, start, stop, clear, meas_ready,
        output seg, cnt_ld, cnt_en, meas_time, meas_valid, overrun, fault, fault_code
    );

    modport slave (
        output sensor, start, stop, clear, meas_ready,
        input  seg, cnt_ld, cnt_en, meas_time, meas_valid, overrun, fault, fault_code
    );

endinterface
`default_nettype wire

// File: rtl/sensor_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sensor_edge_detect
// Brief    : Rising-edge detector on sensor levels with single/multi-hit flags
// Revision : 1.0 - initial release
// ============================================================================
module sensor_edge_detect import segment_pkg::*; #(
    parameter int unsigned N_SEG = N_SEG_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_track,
    input  wire logic [N_SEG-1:0] i_sensor,
    output logic      [N_SEG-1:0] o_edge,
    output logic                  o_single,
    output logic                  o_multi
);

    logic [N_SEG-1:0] r_prev;
    logic             w_any;
    logic             w_pow2;

    // prev follows the levels every cycle; while tracking (IDLE) edges are
    // suppressed so sensors already high at arm time never fire.
    always_ff @(posedge clk) begin
        if (rst)
            r_prev <= '0;
        else
            r_prev <= i_sensor;
    end

    assign o_edge   = i_track ? '0 : (i_sensor & ~r_prev);
    assign w_any    = |o_edge;
    assign w_pow2   = ((o_edge & (o_edge - {{(N_SEG-1){1'b0}}, 1'b1})) == '0);
    assign o_single = w_any & w_pow2;
    assign o_multi  = w_any & ~w_pow2;

endmodule
`default_nettype wire

// File: rtl/segment_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : segment_sequencer
// Brief    : Segment tracking FSM, transit timer and single-entry measurement buffer
// Revision : 1.0 - initial release
// ============================================================================
module segment_sequencer import segment_pkg::*; #(
    parameter int unsigned      N_SEG   = N_SEG_DEFAULT,
    parameter int unsigned      CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = 16'd50000
) (
    input wire logic            clk,
    input wire logic            rst,
    segment_sequencer_if.master bus
);

    localparam logic [N_SEG-1:0] c_one = {{(N_SEG-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEG_W-1:0] r_seg;
    logic [SEG_W-1:0] w_seg_nxt;
    logic [SEG_W-1:0] w_arm_idx;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] w_timer_inc;
    logic             r_cnt_ld;
    logic             w_cnt_ld_nxt;
    logic             r_cnt_en;
    logic             r_fault;
    logic [1:0]       r_fault_code;
    logic [1:0]       w_fault_code_nxt;
    logic [CNT_W-1:0] r_meas_time;
    logic             r_meas_valid;
    logic             r_overrun;
    logic             w_produce;

    logic [N_SEG-1:0] w_edge;
    logic             w_single;
    logic             w_multi;
    logic [N_SEG-1:0] w_edge_other;
    logic [N_SEG-1:0] w_expect;
    logic             w_accept;
    logic             w_timed_out;

    sensor_edge_detect #(
        .N_SEG (N_SEG)
    ) u_edge (
        .clk      (clk),
        .rst      (rst),
        .i_track  (r_state == ST_IDLE),
        .i_sensor (bus.sensor),
        .o_edge   (w_edge),
        .o_single (w_single),
        .o_multi  (w_multi)
    );

    // Own-sensor edges are ignored; everything else must be exactly the successor.
    assign w_edge_other = w_edge & ~(c_one << r_seg);
    assign w_expect     = c_one << next_seg(r_seg, N_SEG);
    assign w_accept     = (r_state == ST_TIMING) && !bus.stop && (w_edge_other == w_expect);
    // timer+1 is the cycle distance to the last accept when an edge lands now.
    assign w_timer_inc  = (&r_timer) ? r_timer : r_timer + CNT_W'(1);
    assign w_timed_out  = (w_timer_inc >= TIMEOUT);

    always_comb begin
        w_arm_idx = '0;
        for (int unsigned i = 0; i < N_SEG; i++) begin
            if (w_edge[i])
                w_arm_idx = SEG_W'(i);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (bus.stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start)
                        w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_multi)
                        w_state_nxt = ST_FAULT;
                    else if (w_single)
                        w_state_nxt = ST_TIMING;
                end
                ST_TIMING: begin
                    if (!w_accept && ((w_edge_other != '0) || w_timed_out))
                        w_state_nxt = ST_FAULT;
                end
                ST_FAULT: begin
                    if (bus.clear)
                        w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        w_seg_nxt        = r_seg;
        w_cnt_ld_nxt     = 1'b0;
        w_produce        = 1'b0;
        w_timer_nxt      = '0;
        w_fault_code_nxt = r_fault_code;

        if (r_state == ST_ARMED && w_state_nxt == ST_TIMING) begin
            w_seg_nxt    = w_arm_idx;
            w_cnt_ld_nxt = 1'b1;
        end else if (w_accept) begin
            w_seg_nxt    = next_seg(r_seg, N_SEG);
            w_cnt_ld_nxt = 1'b1;
            w_produce    = 1'b1;
        end else if (r_state == ST_TIMING && w_state_nxt == ST_TIMING) begin
            w_timer_nxt  = w_timer_inc;
        end

        if (w_state_nxt == ST_FAULT && r_state != ST_FAULT) begin
            if (r_state == ST_ARMED)
                w_fault_code_nxt = FLT_MULTI;
            else if (w_edge_other != '0)
                w_fault_code_nxt = FLT_ORDER;
            else
                w_fault_code_nxt = FLT_TIMEOUT;
        end else if (w_state_nxt == ST_IDLE) begin
            w_fault_code_nxt = FLT_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= '0;
            r_cnt_ld     <= 1'b0;
            r_cnt_en     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FLT_NONE;
            r_timer      <= '0;
        end else begin
            r_seg        <= w_seg_nxt;
            r_cnt_ld     <= w_cnt_ld_nxt;
            r_cnt_en     <= (w_state_nxt == ST_TIMING);
            r_fault      <= (w_state_nxt == ST_FAULT);
            r_fault_code <= w_fault_code_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    // Single-entry measurement buffer; a full, unaccepted entry wins over new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meas_time  <= '0;
            r_meas_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_produce) begin
            if (!r_meas_valid || bus.meas_ready) begin
                r_meas_time  <= w_timer_inc;
                r_meas_valid <= 1'b1;
            end else begin
                r_overrun    <= 1'b1;
            end
        end else if (r_meas_valid && bus.meas_ready) begin
            r_meas_valid <= 1'b0;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.cnt_ld     = r_cnt_ld;
    assign bus.cnt_en     = r_cnt_en;
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_fault_code;
    assign bus.meas_time  = r_meas_time;
    assign bus.meas_valid = r_meas_valid;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_segment_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_sequencer
// Brief    : Directed self-checking bench for segment_sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    segment_sequencer_if #(.N_SEG(6), .CNT_W(16)) sif ();
    segment_sequencer_if #(.N_SEG(6), .CNT_W(16)) sif2 ();

    segment_sequencer #(
        .N_SEG   (6),
        .CNT_W   (16),
        .TIMEOUT (16'd50000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    segment_sequencer #(
        .N_SEG   (6),
        .CNT_W   (16),
        .TIMEOUT (16'd20)
    ) u_dut_to (
        .clk (clk),
        .rst (rst),
        .bus (sif2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hit(input logic [5:0] m);
        sif.sensor = m;
        tick();
        sif.sensor = '0;
    endtask

    task automatic pulse_start();
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
    endtask

    task automatic pulse_stop();
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;
    endtask

    task automatic pulse_clear();
        sif.clear = 1'b1;
        tick();
        sif.clear = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_seg"},        32'(sif.seg),        32'd0);
        chk({tag, "_cnt_ld"},     32'(sif.cnt_ld),     32'd0);
        chk({tag, "_cnt_en"},     32'(sif.cnt_en),     32'd0);
        chk({tag, "_meas_time"},  32'(sif.meas_time),  32'd0);
        chk({tag, "_meas_valid"}, 32'(sif.meas_valid), 32'd0);
        chk({tag, "_overrun"},    32'(sif.overrun),    32'd0);
        chk({tag, "_fault"},      32'(sif.fault),      32'd0);
        chk({tag, "_fault_code"}, 32'(sif.fault_code), 32'd0);
    endtask

    initial begin
        logic [5:0] m;
        rst             = 1'b1;
        sif.sensor      = '0;
        sif.start       = 1'b0;
        sif.stop        = 1'b0;
        sif.clear       = 1'b0;
        sif.meas_ready  = 1'b1;
        sif2.sensor     = '0;
        sif2.start      = 1'b0;
        sif2.stop       = 1'b0;
        sif2.clear      = 1'b0;
        sif2.meas_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset("rst");

        // Normal lap, 100 cycles per segment
        pulse_start();
        hit(6'b000001);
        chk("lap_arm_seg",    32'(sif.seg),    32'd0);
        chk("lap_arm_cnt_ld", 32'(sif.cnt_ld), 32'd1);
        chk("lap_arm_cnt_en", 32'(sif.cnt_en), 32'd1);
        tick();
        chk("lap_cnt_ld_pulse", 32'(sif.cnt_ld), 32'd0);
        repeat (98) tick();
        for (int k = 1; k <= 6; k++) begin
            m = 6'd1 << (k % 6);
            hit(m);
            chk("lap_seg",        32'(sif.seg),        32'(k % 6));
            chk("lap_meas_valid", 32'(sif.meas_valid), 32'd1);
            chk("lap_meas_time",  32'(sif.meas_time),  32'd100);
            chk("lap_cnt_ld",     32'(sif.cnt_ld),     32'd1);
            tick();
            chk("lap_meas_drain", 32'(sif.meas_valid), 32'd0);
            repeat (98) tick();
        end
        chk("lap_fault",   32'(sif.fault),   32'd0);
        chk("lap_overrun", 32'(sif.overrun), 32'd0);

        // Out-of-order: S3 then S5
        pulse_stop();
        chk("stop_cnt_en", 32'(sif.cnt_en), 32'd0);
        pulse_start();
        hit(6'b000100);
        chk("ooo_seg", 32'(sif.seg), 32'd2);
        repeat (5) tick();
        hit(6'b010000);
        chk("ooo_fault",      32'(sif.fault),      32'd1);
        chk("ooo_fault_code", 32'(sif.fault_code), 32'd2);
        chk("ooo_cnt_en",     32'(sif.cnt_en),     32'd0);
        chk("ooo_seg_frozen", 32'(sif.seg),        32'd2);
        pulse_clear();
        chk("clr_fault",      32'(sif.fault),      32'd0);
        chk("clr_fault_code", 32'(sif.fault_code), 32'd0);

        // Timeout on the TIMEOUT=20 instance: S2 edge at n, fault at n+21
        sif2.start = 1'b1;
        tick();
        sif2.start  = 1'b0;
        sif2.sensor = 6'b000010;
        tick();
        sif2.sensor = '0;
        chk("to_seg", 32'(sif2.seg), 32'd1);
        repeat (19) tick();
        chk("to_early_code", 32'(sif2.fault_code), 32'd0);
        tick();
        chk("to_code",  32'(sif2.fault_code), 32'd3);
        chk("to_fault", 32'(sif2.fault),      32'd1);

        // Backpressure: transits of 10 and 15 cycles with ready low
        sif.meas_ready = 1'b0;
        pulse_start();
        hit(6'b000001);
        repeat (9) tick();
        hit(6'b000010);
        chk("bp_valid1",   32'(sif.meas_valid), 32'd1);
        chk("bp_time1",    32'(sif.meas_time),  32'd10);
        chk("bp_overrun0", 32'(sif.overrun),    32'd0);
        repeat (14) tick();
        hit(6'b000100);
        chk("bp_seg",      32'(sif.seg),        32'd2);
        chk("bp_valid2",   32'(sif.meas_valid), 32'd1);
        chk("bp_time_kept",32'(sif.meas_time),  32'd10);
        chk("bp_overrun1", 32'(sif.overrun),    32'd1);
        sif.meas_ready = 1'b1;
        tick();
        chk("bp_drained",       32'(sif.meas_valid), 32'd0);
        chk("bp_overrun_stick", 32'(sif.overrun),    32'd1);
        pulse_stop();

        // Multi-hit in ARMED
        pulse_start();
        hit(6'b001001);
        chk("multi_fault",  32'(sif.fault),      32'd1);
        chk("multi_code",   32'(sif.fault_code), 32'd1);
        chk("multi_cnt_ld", 32'(sif.cnt_ld),     32'd0);
        pulse_clear();
        chk("multi_clr_code", 32'(sif.fault_code), 32'd0);

        // stop together with the expected edge
        pulse_start();
        hit(6'b000001);
        repeat (4) tick();
        sif.sensor = 6'b000010;
        sif.stop   = 1'b1;
        tick();
        sif.sensor = '0;
        sif.stop   = 1'b0;
        chk("stopedge_cnt_en", 32'(sif.cnt_en),     32'd0);
        chk("stopedge_valid",  32'(sif.meas_valid), 32'd0);
        chk("stopedge_cnt_ld", 32'(sif.cnt_ld),     32'd0);
        chk("stopedge_seg",    32'(sif.seg),        32'd0);
        tick();
        chk("stopedge_valid2", 32'(sif.meas_valid), 32'd0);

        // Reset mid-run with a pending measurement; S2 stays high
        sif.meas_ready = 1'b0;
        pulse_start();
        hit(6'b000001);
        repeat (4) tick();
        sif.sensor = 6'b000010;
        tick();
        chk("mid_valid",   32'(sif.meas_valid), 32'd1);
        chk("mid_time",    32'(sif.meas_time),  32'd5);
        chk("mid_overrun", 32'(sif.overrun),    32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("midrst");
        sif.meas_ready = 1'b1;
        tick();
        pulse_start();
        repeat (3) tick();
        chk("rearm_cnt_ld", 32'(sif.cnt_ld), 32'd0);
        chk("rearm_cnt_en", 32'(sif.cnt_en), 32'd0);
        sif.sensor = '0;
        tick();
        hit(6'b000100);
        chk("rearm_seg",    32'(sif.seg),    32'd2);
        chk("rearm_cnt_en2",32'(sif.cnt_en), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
